lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  MEM-stage load/store initiator driving the word-wide data memory port (mem_a/mem_we/mem_wd/mem_rd).
//  Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW: sub-word extraction + sign/zero extension on loads,
//  read-modify-write merge for SB/SH (memory has no byte enables). Flags misaligned/out-of-range accesses.
//  Pipeline stalls while req_ready=0; result returned on a one-cycle resp_valid pulse.
// PARAMETERS
//  MEM_WORDS    64  number of 32-bit words in data memory; word index >= MEM_WORDS is out of range
//  CHECK_RANGE  1   1: out-of-range access -> error response; 0: range check disabled
// PORTS
//  clk         in   1   system clock, all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   MEM stage presents an access
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr    in   32  byte address (ALU result)
//  req_wdata   in   32  store data (rs2); low byte/half used for SB/SH
//  req_ready   out  1   1 only in IDLE; request accepted when req_valid & req_ready at posedge
//  resp_valid  out  1   one-cycle completion pulse
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   valid with resp_valid: misaligned, illegal funct3 or out of range
//  mem_a       out  32  word-aligned byte address {addr[31:2],2'b00}; 0 when idle
//  mem_we      out  1   write strobe, asserted only in WRITE state
//  mem_wd      out  32  write data (full word or merged word)
//  mem_rd      in   32  combinational read data for mem_a
// BEHAVIOUR
//  Reset: state=IDLE, all internal regs 0; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//   mem_a=0, mem_we=0, mem_wd=0. rst in any state aborts the access; mem_we is gated by !rst,
//   so reset asserted during WRITE suppresses the write. No response is issued for an aborted access.
//  States: IDLE, LOAD, RD, WRITE, RESP.
//  IDLE: on accept latch we/funct3/addr/wdata and classify:
//   - error if H/HU/SH with addr[0]=1, W/SW with addr[1:0]!=0, load funct3 in {011,110,111},
//     store funct3 > 010, or (CHECK_RANGE && addr[31:2] >= MEM_WORDS) -> RESP with err=1, no mem access.
//   - load -> LOAD; SW -> WRITE (wd=wdata); SB/SH -> RD.
//  LOAD: mem_a driven, mem_we=0; at posedge capture lane of mem_rd by addr[1:0]: B/BU byte
//   mem_rd[8*addr[1:0]+:8], H/HU half mem_rd[16*addr[1]+:16]; sign-extend B/H, zero-extend BU/HU -> RESP.
//  RD: mem_a driven, mem_we=0; at posedge merged word <= mem_rd with byte/half lane replaced by
//   wdata[7:0]/wdata[15:0]; other lanes preserved -> WRITE.
//  WRITE: mem_a driven, mem_we=1 for exactly one cycle, mem_wd = full or merged word -> RESP.
//  RESP: resp_valid=1, req_ready=0 -> IDLE. resp_rdata/resp_err hold until next RESP.
//  Latency accept->resp_valid: error 1, LW/LB/LH 2, SW 2, SB/SH 3 cycles. Next accept in cycle after RESP.
//  req_valid/req_* ignored outside IDLE; inputs need not stay stable after accept.
//  mem_wd, mem_a are 0 in IDLE and RESP; mem_we never asserted outside WRITE.
// TESTING
//  1 Reset mid-access: SB accepted, rst in WRITE cycle -> mem_we stays 0, word unchanged, IDLE next cycle.
//  2 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> one mem_we pulse, resp_rdata=0xDEADBEEF, err=0,
//    each response 2 cycles after accept.
//  3 Word 0x10 = 0x11223344; SB 0x13 wdata 0x000000AA -> memory 0xAA223344, response 3 cycles
//    after accept; then SH 0x10 wdata 0x5566 -> 0xAA225566.
//  4 Word 0x20 = 0x80FF7F01: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80FF;
//    LHU 0x20 -> 0x00007F01; LB 0x20 -> 0x00000001.
//  5 Errors: LW 0x11, SH 0x21, load funct3=011, SW 0x100 (word 64, MEM_WORDS=64) -> each resp_err=1,
//    resp_rdata=0, mem_we never asserted, 1-cycle latency.
//  6 Back-to-back req_valid held high with SB then LW -> second accepted only after RESP; req_ready low
//    throughout; LW returns merged value.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator for a word-wide data memory (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW).
// Latency accept->resp_valid: error 1, loads 2, SW 2, SB/SH 3 (read-modify-write) cycles.
// Backpressure: req_ready is high only in IDLE; requests presented in any other state are ignored.
module lsu_mem_ctrl #(
  parameter int MEM_WORDS   = 64,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RD    = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [30:0] WORD_LIM = 31'(MEM_WORDS);

  state_t      state, state_nxt;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wd;      // store data, replaced by the merged word after RD
  logic [31:0] r_rdata;
  logic        r_err;

  logic        accept;
  logic        f3_bad, misaligned, out_of_range, req_bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = req_valid & req_ready;

  // Classify the incoming request: illegal funct3, misalignment, or word index past the memory
  always_comb begin
    f3_bad = 1'b0;
    if (req_we)
      f3_bad = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else
      f3_bad = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    misaligned   = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                   ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    out_of_range = CHECK_RANGE & ({1'b0, req_addr[31:2]} >= WORD_LIM);
    req_bad      = f3_bad | misaligned | out_of_range;
  end

  // Pick the addressed lane out of the read word and extend it according to funct3
  always_comb begin
    lane_b   = mem_rd[{r_addr[1:0], 3'b000} +: 8];
    lane_h   = mem_rd[{r_addr[1], 4'b0000} +: 16];
    load_ext = mem_rd;
    case (r_f3)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = mem_rd;
    endcase
  end

  // Replace the byte/half lane of the read word with store data, keeping the other lanes
  always_comb begin
    merged = mem_rd;
    if (r_f3[1:0] == 2'b00)
      merged[{r_addr[1:0], 3'b000} +: 8] = r_wd[7:0];
    else
      merged[{r_addr[1], 4'b0000} +: 16] = r_wd[15:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic: errors skip memory, SW writes directly, SB/SH read first
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)
            state_nxt = S_RESP;
          else if (!req_we)
            state_nxt = S_LOAD;
          else if (req_funct3[1:0] == 2'b10)
            state_nxt = S_WRITE;
          else
            state_nxt = S_RD;
        end
      end
      S_LOAD:  state_nxt = S_RESP;
      S_RD:    state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, load capture, merge capture and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f3    <= 3'b000;
      r_addr  <= 32'h0;
      r_wd    <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            r_f3   <= req_funct3;
            r_addr <= req_addr;
            r_wd   <= req_wdata;
            if (req_bad) begin
              r_rdata <= 32'h0;
              r_err   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_rdata <= load_ext;
          r_err   <= 1'b0;
        end
        S_RD: r_wd <= merged;
        S_WRITE: begin
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: memory port only driven during LOAD/RD/WRITE; write strobe dropped under reset
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    mem_a      = 32'h0;
    mem_we     = 1'b0;
    mem_wd     = 32'h0;
    if ((state == S_LOAD) || (state == S_RD) || (state == S_WRITE))
      mem_a = {r_addr[31:2], 2'b00};
    if (state == S_WRITE) begin
      mem_we = ~rst;
      mem_wd = r_wd;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl against a behavioural word-memory model.
// Latency: n/a (bench); each access is checked for latency, response and memory side effects.
// Backpressure: requests are only presented while req_ready is high, except the held-valid case.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] tb_mem  [0:63];
  logic [31:0] ref_mem [0:63];
  int          we_count = 0;
  logic [31:0] last_wa  = 32'h0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  lsu_mem_ctrl #(.MEM_WORDS(64), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Combinational memory read
  always_comb begin
    mem_rd = 32'hBAD0BAD0;
    if (mem_a[31:8] == 24'h0)
      mem_rd = tb_mem[mem_a[7:2]];
  end

  // Memory write and write-strobe monitor
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      we_count = we_count + 1;
      last_wa  = mem_a;
      if (mem_a[31:8] == 24'h0)
        tb_mem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    tb_mem[idx]  = val;
    ref_mem[idx] = val;
  endtask

  // Reference: what the access should do, computed from RV32I rules on a word array
  task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                        output int e_lat, output int e_wr);
    longint unsigned idx;
    int size, off;
    bit legal;
    logic [31:0] w, mask;
    idx  = longint'(addr) / 4;
    off  = int'(addr % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    e_rd = 32'h0; e_wr = 0;
    if (!legal || (addr % size != 0) || idx >= 64) begin
      e_err = 1'b1; e_lat = 1;
    end else if (!we) begin
      e_err = 1'b0; e_lat = 2;
      w = ref_mem[idx] >> (8 * off);
      if (size == 1) begin
        e_rd = w & 32'hFF;
        if (f3 == 3'd0 && e_rd >= 32'h80) e_rd = e_rd | 32'hFFFFFF00;
      end else if (size == 2) begin
        e_rd = w & 32'hFFFF;
        if (f3 == 3'd1 && e_rd >= 32'h8000) e_rd = e_rd | 32'hFFFF0000;
      end else
        e_rd = ref_mem[idx];
    end else begin
      e_err = 1'b0; e_wr = 1;
      if (size == 4) begin
        ref_mem[idx] = wd; e_lat = 2;
      end else begin
        mask = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
        ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << (8 * off)) & mask);
        e_lat = 3;
      end
    end
  endtask

  // Wait for resp_valid at negedges; returns cycles since the accepting edge (bounded)
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (resp_valid !== 1'b1 && lat < 12);
  endtask

  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic e_err; logic [31:0] e_rd; int e_lat, e_wr, wc0, lat;
    ref_op(we, f3, addr, wd, e_err, e_rd, e_lat, e_wr);
    @(negedge clk);
    check({tag, ".rdy"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    wc0 = we_count;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    wait_resp(lat);
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check({tag, ".err"}, {31'h0, resp_err}, {31'h0, e_err});
    check({tag, ".rdata"}, resp_rdata, e_rd);
    check({tag, ".wecnt"}, 32'(we_count - wc0), 32'(e_wr));
    if (e_wr != 0) begin
      check({tag, ".wa"}, last_wa, {addr[31:2], 2'b00});
      check({tag, ".word"}, tb_mem[addr[7:2]], ref_mem[addr[7:2]]);
    end
  endtask

  initial begin
    int lat, wc0;
    logic e_err; logic [31:0] e_rd; int e_lat, e_wr;
    logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready", {31'h0, req_ready}, 32'h1);
    check("rst.rvalid", {31'h0, resp_valid}, 32'h0);
    check("rst.rdata", resp_rdata, 32'h0);
    check("rst.err", {31'h0, resp_err}, 32'h0);
    check("rst.mem_a", mem_a, 32'h0);
    check("rst.mem_we", {31'h0, mem_we}, 32'h0);
    check("rst.mem_wd", mem_wd, 32'h0);
    rst = 1'b0;

    // Reset during the WRITE cycle of an SB: no write, no response, IDLE afterwards
    preload(5, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h15; req_wdata = 32'h55;
    wc0 = we_count;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rstw.mem_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstw.ready", {31'h0, req_ready}, 32'h1);
    check("rstw.rvalid", {31'h0, resp_valid}, 32'h0);
    check("rstw.mem_a", mem_a, 32'h0);
    check("rstw.word", tb_mem[5], 32'hCAFEF00D);
    check("rstw.wecnt", 32'(we_count - wc0), 32'h0);

    // SW then LW
    do_op("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_op("lw10", 1'b0, 3'd2, 32'h10, 32'h0);
    check("lw10.val", resp_rdata, 32'hDEADBEEF);

    // SB / SH read-modify-write
    preload(4, 32'h11223344);
    do_op("sb13", 1'b1, 3'd0, 32'h13, 32'h000000AA);
    check("sb13.val", tb_mem[4], 32'hAA223344);
    do_op("sh10", 1'b1, 3'd1, 32'h10, 32'h00005566);
    check("sh10.val", tb_mem[4], 32'hAA225566);

    // Sub-word loads with sign/zero extension
    preload(8, 32'h80FF7F01);
    do_op("lb23", 1'b0, 3'd0, 32'h23, 32'h0);
    check("lb23.val", resp_rdata, 32'hFFFFFF80);
    do_op("lbu23", 1'b0, 3'd4, 32'h23, 32'h0);
    check("lbu23.val", resp_rdata, 32'h00000080);
    do_op("lh22", 1'b0, 3'd1, 32'h22, 32'h0);
    check("lh22.val", resp_rdata, 32'hFFFF80FF);
    do_op("lhu20", 1'b0, 3'd5, 32'h20, 32'h0);
    check("lhu20.val", resp_rdata, 32'h00007F01);
    do_op("lb20", 1'b0, 3'd0, 32'h20, 32'h0);
    check("lb20.val", resp_rdata, 32'h00000001);

    // Error responses
    do_op("e_lw11", 1'b0, 3'd2, 32'h11, 32'h0);
    do_op("e_sh21", 1'b1, 3'd1, 32'h21, 32'h1234);
    do_op("e_f3", 1'b0, 3'd3, 32'h20, 32'h0);
    do_op("e_sw100", 1'b1, 3'd2, 32'h100, 32'h12345678);
    check("e_sw100.err", {31'h0, resp_err}, 32'h1);

    // Held req_valid: SB then LW, second accepted only after RESP
    preload(12, 32'h01020304);
    ref_op(1'b1, 3'd0, 32'h31, 32'h77, e_err, e_rd, e_lat, e_wr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h31; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'h0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      check("b2b.rdy_low", {31'h0, req_ready}, 32'h0);
    end while (resp_valid !== 1'b1 && lat < 12);
    check("b2b.sb_lat", 32'(lat), 32'(e_lat));
    @(negedge clk);
    check("b2b.rdy_back", {31'h0, req_ready}, 32'h1);
    check("b2b.no_dup", {31'h0, resp_valid}, 32'h0);
    ref_op(1'b0, 3'd2, 32'h30, 32'h0, e_err, e_rd, e_lat, e_wr);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_resp(lat);
    check("b2b.lw_lat", 32'(lat), 32'(e_lat));
    check("b2b.lw_val", resp_rdata, 32'h01027704);
    check("b2b.lw_ref", resp_rdata, e_rd);

    // Randomized mix of loads/stores, mostly legal, some misaligned/illegal/out of range
    for (int i = 0; i < 200; i++) begin
      logic [2:0] f3; logic [31:0] a; logic w;
      w  = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : f3s[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0)
        a = $urandom;
      else
        a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1 && f3[1:0] == 2'd1) a[0] = 1'b0;
      if ($urandom_range(0, 1) == 1 && f3[1:0] == 2'd2) a[1:0] = 2'b00;
      do_op("rnd", w, f3, a, $urandom);
    end
    for (int i = 0; i < 64; i++) check("final.mem", tb_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
